// File: rtl/fft_frame_rx.sv
// fft_frame_rx: AXI-stream receiver for complex FFT output frames.
// Numbers the accepted beats as bins, checks that tlast lands on bin FFT_POINT-1,
// streams a per-bin magnitude with two cycles of latency, and reports each frame's peak.
// Define FFT_RX_ALPHAMAX_EN to replace |re|+|im| with max + min/2 as the magnitude.
module fft_frame_rx #(
  parameter int FFT_POINT = 8192,
  parameter int DATA_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic [2*DATA_W-1:0]          s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic                         s_tlast,
  output logic                         o_valid,
  output logic [$clog2(FFT_POINT)-1:0] o_bin,
  output logic [DATA_W:0]              o_mag,
  output logic                         o_peak_valid,
  output logic [$clog2(FFT_POINT)-1:0] o_peak_bin,
  output logic [DATA_W:0]              o_peak_mag,
  output logic                         o_err_early,
  output logic                         o_err_late
);

  localparam int BIN_W = $clog2(FFT_POINT);
  localparam int MAG_W = DATA_W + 1;
  localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_POINT - 1);
  localparam logic [BIN_W-1:0] BinOne  = BIN_W'(1);

  typedef enum logic {StRun, StResync} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic beat_emit, beat_first, beat_last;
  logic err_early_d, err_late_d;

  // Magnitude pipeline stage 1 registers
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [BIN_W-1:0] s1_bin;
  logic [MAG_W-1:0] s1_abs_re, s1_abs_im;

  // Stage 2 combinational results and peak accumulator
  logic [MAG_W-1:0] mag_s2;
  logic             pk_take;
  logic [BIN_W-1:0] pk_bin_q;
  logic [MAG_W-1:0] pk_mag_q;
  logic             pub_q;

  // Absolute values of the incoming beat, computed one bit wider so that -2^(DATA_W-1) fits
  logic [DATA_W-1:0] re_in, im_in;
  logic [MAG_W-1:0]  re_ext, im_ext, abs_re, abs_im;

  assign s_tready = i_enable;
  assign accept   = s_tvalid & i_enable;

  // Magnitude of each component, computed from the sign-extended input
  always_comb begin
    re_in  = s_tdata[DATA_W-1:0];
    im_in  = s_tdata[2*DATA_W-1:DATA_W];
    re_ext = {re_in[DATA_W-1], re_in};
    im_ext = {im_in[DATA_W-1], im_in};
    abs_re = re_in[DATA_W-1] ? ({MAG_W{1'b0}} - re_ext) : re_ext;
    abs_im = im_in[DATA_W-1] ? ({MAG_W{1'b0}} - im_ext) : im_ext;
  end

  // Framing FSM: bin numbering, tlast checks and resync after a missing tlast
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_emit   = 1'b0;
    beat_first  = 1'b0;
    beat_last   = 1'b0;
    err_early_d = 1'b0;
    err_late_d  = 1'b0;
    if (accept) begin
      unique case (state_q)
        StRun: begin
          beat_emit  = 1'b1;
          beat_first = (cnt_q == '0);
          if (cnt_q == LastBin) begin
            cnt_d = '0;
            if (s_tlast) begin
              beat_last = 1'b1;
            end else begin
              err_late_d = 1'b1;
              state_d    = StResync;
            end
          end else if (s_tlast) begin
            // Short frame: the beat is still shown, but the peak is never published
            err_early_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + BinOne;
          end
        end
        StResync: begin
          if (s_tlast) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // FSM state, bin counter and registered error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      o_err_early <= 1'b0;
      o_err_late  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      o_err_early <= err_early_d;
      o_err_late  <= err_late_d;
    end
  end

  // Stage 1: latch absolute values together with bin number and frame-edge flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_bin    <= '0;
      s1_abs_re <= '0;
      s1_abs_im <= '0;
    end else begin
      s1_valid <= beat_emit;
      if (beat_emit) begin
        s1_first  <= beat_first;
        s1_last   <= beat_last;
        s1_bin    <= cnt_q;
        s1_abs_re <= abs_re;
        s1_abs_im <= abs_im;
      end
    end
  end

  // Stage 2 magnitude and peak-replace decision
`ifdef FFT_RX_ALPHAMAX_EN
  logic [MAG_W-1:0] mx, mn;
  always_comb begin
    mx      = (s1_abs_re > s1_abs_im) ? s1_abs_re : s1_abs_im;
    mn      = (s1_abs_re > s1_abs_im) ? s1_abs_im : s1_abs_re;
    mag_s2  = mx + (mn >> 1);
    pk_take = s1_valid & (s1_first | (mag_s2 > pk_mag_q));
  end
`else
  always_comb begin
    mag_s2  = s1_abs_re + s1_abs_im;
    // Strictly greater: on a tie the lower bin wins
    pk_take = s1_valid & (s1_first | (mag_s2 > pk_mag_q));
  end
`endif

  // Stage 2: magnitude output and peak accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_bin    <= '0;
      o_mag    <= '0;
      pk_bin_q <= '0;
      pk_mag_q <= '0;
      pub_q    <= 1'b0;
    end else begin
      o_valid <= s1_valid;
      pub_q   <= s1_valid & s1_last;
      if (s1_valid) begin
        o_bin <= s1_bin;
        o_mag <= mag_s2;
      end
      if (pk_take) begin
        pk_bin_q <= s1_bin;
        pk_mag_q <= mag_s2;
      end
    end
  end

  // Stage 3: publish the peak; a following bin 0 overwrites the accumulator only after this read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_peak_valid <= 1'b0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
    end else begin
      o_peak_valid <= pub_q;
      if (pub_q) begin
        o_peak_bin <= pk_bin_q;
        o_peak_mag <= pk_mag_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_rx.sv
// Bench for fft_frame_rx (FFT_POINT=16, DATA_W=16): directed frames and a random stream,
// checked on every cycle against a frame-level reference model.
module tb_fft_frame_rx;
  localparam int N = 16;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b0;
  logic [2*W-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          o_valid;
  logic [3:0]    o_bin;
  logic [W:0]    o_mag;
  logic          o_peak_valid;
  logic [3:0]    o_peak_bin;
  logic [W:0]    o_peak_mag;
  logic          o_err_early;
  logic          o_err_late;

  fft_frame_rx #(.FFT_POINT(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .o_valid     (o_valid),
    .o_bin       (o_bin),
    .o_mag       (o_mag),
    .o_peak_valid(o_peak_valid),
    .o_peak_bin  (o_peak_bin),
    .o_peak_mag  (o_peak_mag),
    .o_err_early (o_err_early),
    .o_err_late  (o_err_late)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference magnitude straight from the definition
  function automatic int magf(input logic [15:0] re, input logic [15:0] im);
    int a, b;
    a = $signed(re);
    b = $signed(im);
    if (a < 0) a = -a;
    if (b < 0) b = -b;
`ifdef FFT_RX_ALPHAMAX_EN
    return (a > b) ? (a + (b >> 1)) : (b + (a >> 1));
`else
    return a + b;
`endif
  endfunction

  // Reference model: expected events keyed by the clock edge after which they are visible
  int  ecyc = 0;
  int  ev_mag[int];
  int  ev_bin[int];
  int  ev_pbin[int];
  int  ev_pmag[int];
  bit  ev_early[int];
  bit  ev_late[int];
  bit  m_resync = 0;
  int  m_cnt = 0;
  int  fr_mag[$];
  int  h_bin = 0, h_mag = 0, h_pbin = 0, h_pmag = 0;
  int  m_tmp, pb, pm;
  bit  e_v, e_p, e_e, e_l;

  always @(posedge clk) begin
    ecyc++;
    if (rst) begin
      ev_mag.delete(); ev_bin.delete(); ev_pbin.delete(); ev_pmag.delete();
      ev_early.delete(); ev_late.delete();
      m_resync = 0; m_cnt = 0; fr_mag.delete();
      h_bin = 0; h_mag = 0; h_pbin = 0; h_pmag = 0;
    end else if (s_tvalid && i_enable) begin
      m_tmp = magf(s_tdata[15:0], s_tdata[31:16]);
      if (!m_resync) begin
        ev_mag[ecyc+1] = m_tmp;
        ev_bin[ecyc+1] = m_cnt;
        fr_mag.push_back(m_tmp);
        if (m_cnt == N - 1) begin
          if (s_tlast) begin
            pb = 0; pm = fr_mag[0];
            for (int i = 1; i < fr_mag.size(); i++) if (fr_mag[i] > pm) begin pm = fr_mag[i]; pb = i; end
            ev_pbin[ecyc+2] = pb;
            ev_pmag[ecyc+2] = pm;
          end else begin
            ev_late[ecyc] = 1;
            m_resync = 1;
          end
          m_cnt = 0; fr_mag.delete();
        end else if (s_tlast) begin
          ev_early[ecyc] = 1;
          m_cnt = 0; fr_mag.delete();
        end else begin
          m_cnt++;
        end
      end else if (s_tlast) begin
        m_resync = 0; m_cnt = 0;
      end
    end
    #1;
    e_v = ev_mag.exists(ecyc);
    if (e_v) begin h_mag = ev_mag[ecyc]; h_bin = ev_bin[ecyc]; end
    e_p = ev_pbin.exists(ecyc);
    if (e_p) begin h_pmag = ev_pmag[ecyc]; h_pbin = ev_pbin[ecyc]; end
    e_e = ev_early.exists(ecyc);
    e_l = ev_late.exists(ecyc);
    check("s_tready", s_tready, i_enable);
    check("o_valid", o_valid, e_v);
    check("o_bin", o_bin, h_bin);
    check("o_mag", o_mag, h_mag);
    check("o_peak_valid", o_peak_valid, e_p);
    check("o_peak_bin", o_peak_bin, h_pbin);
    check("o_peak_mag", o_peak_mag, h_pmag);
    check("o_err_early", o_err_early, e_e);
    check("o_err_late", o_err_late, e_l);
  end

  // Present one beat, retrying until accepted; stall_pct randomly drops i_enable
  task automatic send(input int re, input int im, input bit last, input int stall_pct);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    s_tdata  = {16'(im), 16'(re)};
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!acc && tries < 200) begin
      i_enable = ($urandom_range(99) >= stall_pct);
      @(posedge clk);
      acc = i_enable;
      tries++;
      @(negedge clk);
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles", tries);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    i_enable = 1'b1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clean_frame();
    for (int b = 0; b < N; b++) send(b, -b, b == N - 1, 0);
  endtask

  initial begin
    int p;
    bit last;
    repeat (3) @(negedge clk);
    check("reset_o_mag", o_mag, 0);
    check("reset_o_peak_mag", o_peak_mag, 0);
    rst = 1'b0;
    i_enable = 1'b1;

    // Clean frame: mag = 2*bin, peak at bin 15
    clean_frame();
    idle(5);
    check("clean_peak_bin", o_peak_bin, 15);
`ifdef FFT_RX_ALPHAMAX_EN
    check("clean_peak_mag", o_peak_mag, 22);
`else
    check("clean_peak_mag", o_peak_mag, 30);
`endif

    // Most negative values in bins 3 and 9 tie at 32768; lower bin wins
    for (int b = 0; b < N; b++)
      send((b == 3) ? -32768 : 0, (b == 9) ? -32768 : 0, b == N - 1, 0);
    idle(5);
    check("extreme_peak_bin", o_peak_bin, 3);
    check("extreme_peak_mag", o_peak_mag, 32768);

    // Early tlast on beat 10, then a clean frame
    for (int b = 0; b <= 10; b++) send(b + 1, 3, b == 10, 0);
    clean_frame();
    idle(4);

    // Late tlast: 20 beats, tlast on 19; then a clean frame
    for (int b = 0; b < 20; b++) send(b, b, b == 19, 0);
    clean_frame();
    idle(4);

    // Five-cycle stall holding bin 7
    for (int b = 0; b < 7; b++) send(b, 2 * b, 0, 0);
    s_tdata = {16'(14), 16'(7)};
    s_tvalid = 1'b1;
    i_enable = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 check("stall_tready", s_tready, 0);
    end
    @(negedge clk);
    for (int b = 7; b < N; b++) send(b, 2 * b, b == N - 1, 0);

    // Reset at bin 4 of the next frame
    for (int b = 0; b < 4; b++) send(100 + b, -5, 0, 0);
    rst = 1'b1;
    #1;
    check("midreset_o_valid", o_valid, 0);
    check("midreset_o_mag", o_mag, 0);
    check("midreset_o_peak_bin", o_peak_bin, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clean_frame();
    idle(4);

    // Random stream with stalls, gaps and occasional bad framing
    p = 0;
    for (int k = 0; k < 700; k++) begin
      if (p >= N - 1) last = ($urandom_range(9) != 0);
      else last = ($urandom_range(39) == 0);
      send($urandom_range(65535), $urandom_range(65535), last, 20);
      p = last ? 0 : p + 1;
      if ($urandom_range(7) == 0) idle($urandom_range(3));
    end
    idle(4);

    // Magnitude of re=100, im=-40
    send(100, -40, 0, 0);
    @(posedge clk);
    #2;
`ifdef FFT_RX_ALPHAMAX_EN
    check("macro_mag", o_mag, 120);
`else
    check("macro_mag", o_mag, 140);
`endif
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
